// File: rtl/disp_timing_ctrl.sv
// Display timing controller: free-running h/v counters, combinational pixel request toward the
// pixel source, one registered stage producing aligned sync/de/rgb, frame-aligned start/stop FSM.
module disp_timing_ctrl #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_DISP   = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int SYNC_POL = 0
) (
  input  logic        clk_disp,
  input  logic        reset,
  input  logic        en,
  input  logic [23:0] disp_data,
  output logic [11:0] disp_h_addr,
  output logic [11:0] disp_v_addr,
  output logic        disp_data_req,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_BEG  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_ACT_BEG  = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] H_ACT_END  = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] V_ACT_END  = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic        SYNC_ON    = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        last_px;
  logic        h_act_p0;
  logic        v_act_p0;
  logic        active_p0;

  logic        hsync_p1;
  logic        vsync_p1;
  logic        vld_p1;
  logic [23:0] rgb_p1;
  logic        frame_start_p1;

  assign last_px = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Stopping is only honoured on the last pixel, so a frame is never cut short.
  always_ff @(posedge clk_disp) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= last_px ? IDLE : DRAIN;
        DRAIN: begin
          if (last_px)  state <= en ? RUN : IDLE;
          else if (en)  state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_disp) begin
    if (reset || state == IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage 0: combinational request/address toward the pixel source
  always_comb begin
    h_act_p0    = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_act_p0    = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    active_p0   = h_act_p0 && v_act_p0 && (state != IDLE);
    disp_h_addr = active_p0 ? h_cnt - H_ACT_BEG : 12'd0;
    disp_v_addr = active_p0 ? v_cnt - V_ACT_BEG : 12'd0;
  end

  assign disp_data_req = active_p0;
  assign busy          = (state != IDLE);

  // Stage 1: registered outputs, captured pixel aligned with de
  always_ff @(posedge clk_disp) begin
    if (reset || state == IDLE) begin
      hsync_p1       <= ~SYNC_ON;
      vsync_p1       <= ~SYNC_ON;
      vld_p1         <= 1'b0;
      rgb_p1         <= '0;
      frame_start_p1 <= 1'b0;
    end else begin
      hsync_p1       <= (h_cnt < H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
      vsync_p1       <= (v_cnt < V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
      vld_p1         <= active_p0;
      rgb_p1         <= active_p0 ? disp_data : 24'd0;
      frame_start_p1 <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign de          = vld_p1;
  assign rgb         = rgb_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// Bench for disp_timing_ctrl: a full-size instance for line/sync timing and the first active
// pixel, and a shrunken instance checked every cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_disp_timing_ctrl;

  localparam int SH_SYNC = 4, SH_BACK = 3, SH_DISP = 10, SH_FRONT = 2;
  localparam int SV_SYNC = 2, SV_BACK = 3, SV_DISP = 6, SV_FRONT = 2;
  localparam int SHT = SH_SYNC + SH_BACK + SH_DISP + SH_FRONT;
  localparam int SVT = SV_SYNC + SV_BACK + SV_DISP + SV_FRONT;
  localparam int SFT = SHT * SVT;
  localparam int SHS = SH_SYNC + SH_BACK;
  localparam int SVS = SV_SYNC + SV_BACK;
  localparam int BHT = 1056;
  localparam int BHS = 216;
  localparam int BVS = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        en_b  = 1'b0;
  logic        en_s  = 1'b0;
  logic [23:0] pat_seed = 24'h0;

  logic [11:0] ha_b, va_b, ha_s, va_s;
  logic        req_b, hs_b, vs_b, de_b, fs_b, busy_b;
  logic        req_s, hs_s, vs_s, de_s, fs_s, busy_s;
  logic [23:0] rgb_b, rgb_s, data_b, data_s;

  int n_chk  = 0;
  int n_pass = 0;
  int big_k  = 0;

  // Colour-bar source: 8 vertical bars, row-dependent tint, randomised per scenario.
  function automatic logic [23:0] pix(input logic [11:0] ha, input logic [11:0] va,
                                      input int hdisp, input logic [23:0] seed);
    int          bar;
    logic [23:0] c;
    bar = (int'(ha) * 8) / hdisp;
    case (bar)
      0:       c = 24'hFFFFFF;
      1:       c = 24'hFFFF00;
      2:       c = 24'h00FFFF;
      3:       c = 24'h00FF00;
      4:       c = 24'hFF00FF;
      5:       c = 24'hFF0000;
      6:       c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c ^ seed ^ {12'h0, va};
  endfunction

  assign data_b = pix(ha_b, va_b, 800, pat_seed);
  assign data_s = pix(ha_s, va_s, SH_DISP, pat_seed);

  disp_timing_ctrl dut_big (
    .clk_disp(clk), .reset(reset), .en(en_b), .disp_data(data_b),
    .disp_h_addr(ha_b), .disp_v_addr(va_b), .disp_data_req(req_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b),
    .frame_start(fs_b), .busy(busy_b)
  );

  disp_timing_ctrl #(
    .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_DISP(SH_DISP), .H_FRONT(SH_FRONT),
    .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_DISP(SV_DISP), .V_FRONT(SV_FRONT),
    .SYNC_POL(1)
  ) dut_sml (
    .clk_disp(clk), .reset(reset), .en(en_s), .disp_data(data_s),
    .disp_h_addr(ha_s), .disp_v_addr(va_s), .disp_data_req(req_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .rgb(rgb_s),
    .frame_start(fs_s), .busy(busy_s)
  );

  // Full-size frame geometry from a linear position within the frame.
  function automatic logic big_act(input int p);
    int h, v;
    h = p % BHT;
    v = p / BHT;
    return (h >= BHS) && (h < BHS + 800) && (v >= BVS) && (v < BVS + 480);
  endfunction

  function automatic logic [11:0] big_ha(input int p);
    return big_act(p) ? 12'((p % BHT) - BHS) : 12'd0;
  endfunction

  function automatic logic [11:0] big_va(input int p);
    return big_act(p) ? 12'((p / BHT) - BVS) : 12'd0;
  endfunction

  function automatic logic s_act(input int t);
    int h, v;
    h = t % SHT;
    v = t / SHT;
    return (h >= SHS) && (h < SHS + SH_DISP) && (v >= SVS) && (v < SVS + SV_DISP);
  endfunction

  function automatic logic [11:0] s_ha(input int t);
    return s_act(t) ? 12'((t % SHT) - SHS) : 12'd0;
  endfunction

  function automatic logic [11:0] s_va(input int t);
    return s_act(t) ? 12'((t / SHT) - SVS) : 12'd0;
  endfunction

  // Reference model: a frame is either in progress (position m_t) or not; a new frame
  // begins after the last pixel only while en is high.
  logic        m_run = 1'b0;
  int          m_t   = 0;
  logic        e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0, e_fs = 1'b0;
  logic [23:0] e_rgb = 24'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 1'b0;
      m_t   <= 0;
      e_hs  <= 1'b0;
      e_vs  <= 1'b0;
      e_de  <= 1'b0;
      e_rgb <= 24'd0;
      e_fs  <= 1'b0;
    end else begin
      if (m_run) begin
        e_hs  <= (m_t % SHT) < SH_SYNC;
        e_vs  <= (m_t / SHT) < SV_SYNC;
        e_de  <= s_act(m_t);
        e_rgb <= s_act(m_t) ? pix(s_ha(m_t), s_va(m_t), SH_DISP, pat_seed) : 24'd0;
        e_fs  <= (m_t == 0);
        m_t   <= (m_t + 1) % SFT;
        if (m_t == SFT - 1) m_run <= en_s;
      end else begin
        e_hs  <= 1'b0;
        e_vs  <= 1'b0;
        e_de  <= 1'b0;
        e_rgb <= 24'd0;
        e_fs  <= 1'b0;
        m_run <= en_s;
        m_t   <= 0;
      end
    end
  end

  function automatic logic [53:0] s_obs();
    return {busy_s, req_s, ha_s, va_s, hs_s, vs_s, de_s, fs_s, rgb_s};
  endfunction

  function automatic logic [53:0] s_exp();
    return {m_run, m_run && s_act(m_t), m_run ? s_ha(m_t) : 12'd0, m_run ? s_va(m_t) : 12'd0,
            e_hs, e_vs, e_de, e_fs, e_rgb};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    en_s  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en_b  = 1'b0;
    en_s  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if ({de_b, rgb_b, hs_b, vs_b, busy_b, req_b, fs_b} !==
          {1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
        $display("FAIL reset_big cyc %0d got %h want %h", i,
                 {de_b, rgb_b, hs_b, vs_b, busy_b, req_b, fs_b},
                 {1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      else n_pass++;
      n_chk++;
      if (s_obs() !== 54'd0)
        $display("FAIL reset_small cyc %0d got %h want %h", i, s_obs(), 54'd0);
      else n_pass++;
    end
  endtask

  task automatic test_sync_timing();
    logic e_hsb, e_vsb, e_fsb, e_req;
    reset = 1'b0;
    en_b  = 1'b1;
    for (int k = 1; k <= 2200; k++) begin
      step();
      e_hsb = (k >= 2) ? !(((k - 2) % BHT) < 128) : 1'b1;
      e_vsb = (k >= 2) ? !(((k - 2) / BHT) < 2) : 1'b1;
      e_fsb = (k == 2);
      e_req = big_act(k - 1);
      n_chk++;
      if ({hs_b, vs_b, fs_b, busy_b, req_b} !== {e_hsb, e_vsb, e_fsb, 1'b1, e_req})
        $display("FAIL sync_timing k=%0d got %b want %b", k,
                 {hs_b, vs_b, fs_b, busy_b, req_b}, {e_hsb, e_vsb, e_fsb, 1'b1, e_req});
      else n_pass++;
      big_k = k;
    end
  endtask

  task automatic test_first_pixel();
    int          target;
    int          p;
    logic        e_de;
    logic [23:0] e_px;
    target   = BVS * BHT + BHS;
    pat_seed = 24'($urandom);
    for (int k = big_k + 1; k <= target + 4; k++) begin
      step();
      p    = k - 1;
      e_de = big_act(p - 1);
      e_px = e_de ? pix(big_ha(p - 1), big_va(p - 1), 800, pat_seed) : 24'd0;
      n_chk++;
      if ({req_b, ha_b, va_b, de_b, rgb_b} !== {big_act(p), big_ha(p), big_va(p), e_de, e_px})
        $display("FAIL first_pixel p=%0d got %h want %h", p, {req_b, ha_b, va_b, de_b, rgb_b},
                 {big_act(p), big_ha(p), big_va(p), e_de, e_px});
      else n_pass++;
      if (p == target) begin
        n_chk++;
        if ({req_b, ha_b, va_b} !== {1'b1, 12'd0, 12'd0})
          $display("FAIL first_req got %h want %h", {req_b, ha_b, va_b}, {1'b1, 24'd0});
        else n_pass++;
      end
      if (p == target + 1) begin
        n_chk++;
        if ({de_b, rgb_b} !== {1'b1, pix(12'd0, 12'd0, 800, pat_seed)})
          $display("FAIL first_de got %h want %h", {de_b, rgb_b},
                   {1'b1, pix(12'd0, 12'd0, 800, pat_seed)});
        else n_pass++;
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_frames();
    int de_cnt, vs_cnt;
    de_cnt   = 0;
    vs_cnt   = 0;
    pat_seed = 24'($urandom);
    pulse_reset();
    en_s = 1'b1;
    for (int i = 1; i <= 2 * SFT + 5; i++) begin
      step();
      n_chk++;
      if (s_obs() !== s_exp())
        $display("FAIL frames cyc %0d got %h want %h", i, s_obs(), s_exp());
      else n_pass++;
      if (i >= 2 && i <= SFT + 1) begin
        if (de_s) de_cnt++;
        if (vs_s) vs_cnt++;
      end
    end
    n_chk++;
    if (de_cnt != SH_DISP * SV_DISP)
      $display("FAIL frame_de_count got %0d want %0d", de_cnt, SH_DISP * SV_DISP);
    else n_pass++;
    n_chk++;
    if (vs_cnt != SV_SYNC * SHT)
      $display("FAIL frame_vsync_count got %0d want %0d", vs_cnt, SV_SYNC * SHT);
    else n_pass++;
  endtask

  task automatic test_drain();
    int   stop_line, busy_cyc, de_cnt;
    logic done;
    busy_cyc  = 0;
    de_cnt    = 0;
    done      = 1'b0;
    stop_line = $urandom_range(SVS, SVS + SV_DISP - 1);
    pat_seed  = 24'($urandom);
    pulse_reset();
    en_s = 1'b1;
    for (int i = 1; i <= 3 * SFT && !done; i++) begin
      step();
      n_chk++;
      if (s_obs() !== s_exp())
        $display("FAIL drain cyc %0d got %h want %h", i, s_obs(), s_exp());
      else n_pass++;
      if (busy_s) busy_cyc++;
      if (de_s) de_cnt++;
      if (i == stop_line * SHT + 3) en_s = 1'b0;
      if (i > 1 && busy_s === 1'b0) done = 1'b1;
    end
    n_chk++;
    if (!done) $display("FAIL drain_timeout got busy=%b want 0", busy_s);
    else n_pass++;
    n_chk++;
    if (busy_cyc != SFT) $display("FAIL drain_busy_len got %0d want %0d", busy_cyc, SFT);
    else n_pass++;
    n_chk++;
    if (de_cnt != SH_DISP * SV_DISP)
      $display("FAIL drain_de_count got %0d want %0d", de_cnt, SH_DISP * SV_DISP);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if ({busy_s, de_s, hs_s, vs_s, rgb_s, req_s} !== {5'b0, 24'd0, 1'b0})
        $display("FAIL drain_idle cyc %0d got %h want %h", i,
                 {busy_s, de_s, hs_s, vs_s, rgb_s, req_s}, 30'd0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] tgt_ha, tgt_va;
    logic        found;
    found    = 1'b0;
    tgt_ha   = 12'($urandom_range(1, SH_DISP - 2));
    tgt_va   = 12'($urandom_range(0, SV_DISP - 1));
    pat_seed = 24'($urandom);
    pulse_reset();
    en_s = 1'b1;
    for (int i = 1; i <= 2 * SFT && !found; i++) begin
      step();
      n_chk++;
      if (s_obs() !== s_exp())
        $display("FAIL reset_mid_pre cyc %0d got %h want %h", i, s_obs(), s_exp());
      else n_pass++;
      if (req_s === 1'b1 && ha_s === tgt_ha && va_s === tgt_va) found = 1'b1;
    end
    n_chk++;
    if (!found) $display("FAIL reset_mid_target got req=%b want 1", req_s);
    else n_pass++;
    reset = 1'b1;
    step();
    n_chk++;
    if ({de_s, busy_s, req_s, rgb_s, ha_s, va_s} !== {3'b0, 24'd0, 24'd0})
      $display("FAIL reset_mid_after got %h want %h", {de_s, busy_s, req_s, rgb_s, ha_s, va_s},
               51'd0);
    else n_pass++;
    reset = 1'b0;
    for (int i = 1; i <= SFT + 10; i++) begin
      step();
      n_chk++;
      if (s_obs() !== s_exp())
        $display("FAIL reset_mid_post cyc %0d got %h want %h", i, s_obs(), s_exp());
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if ({busy_s, fs_s} !== 2'b11)
          $display("FAIL restart_frame_start got %b want 11", {busy_s, fs_s});
        else n_pass++;
      end
    end
  endtask

  task automatic test_en_toggle();
    pat_seed = 24'($urandom);
    pulse_reset();
    en_s = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      step();
      n_chk++;
      if (s_obs() !== s_exp())
        $display("FAIL en_toggle cyc %0d got %h want %h", i, s_obs(), s_exp());
      else n_pass++;
      if ($urandom_range(0, 59) == 0) en_s = ~en_s;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_sync_timing();
    test_first_pixel();
    test_frames();
    test_drain();
    test_reset_mid();
    test_en_toggle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
